writeback_buffer: RTL
=====================

Name: writeback_buffer

Overview:
- Line-granular write-back buffer between the data cache and the block DataMemory.
- Absorbs dirty-line evictions from the cache so that a miss refill never waits behind a writeback.
- Drains buffered lines to memory oldest-first when idle.
- Forwards a buffered line to the cache when a refill read hits the buffer.

Parameters:
- LINE_SIZE, 16, bytes per cache line; LINE_BITS = LINE_SIZE*8 (128).
- NUM_ENTRIES, 2, buffered lines (power of 2, >=2).
- OFS_BITS, `CLOG2(LINE_SIZE/4)` (2), word-offset bits of a line address.

Ports:
- reset  in  1  synchronous active-high reset
- clk  in  1  single clock, all state on posedge
- c_is_input_valid  in  1  cache request strobe
- c_addr  in  32  word address of line; low OFS_BITS ignored, treated as zero
- c_mem_read  in  1  refill read request
- c_mem_write  in  1  eviction (line write) request
- c_din  in  LINE_BITS  evicted line data
- c_is_ready  out  1  buffer accepts a request this cycle
- c_is_output_valid  out  1  one-cycle pulse, c_dout valid
- c_dout  out  LINE_BITS  refill line data
- m_is_input_valid  out  1  memory request strobe
- m_addr  out  32  memory line address, low OFS_BITS zero
- m_mem_read  out  1  memory read
- m_mem_write  out  1  memory write
- m_din  out  LINE_BITS  line data to memory
- m_is_output_valid  in  1  memory read data valid pulse
- m_dout  in  LINE_BITS  memory read data
- m_mem_ready  in  1  memory accepts request

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset:
  - state=IDLE; count, head and tail = 0; all entry valid bits cleared.
  - All outputs 0, except c_is_ready = 1 the first cycle after reset.
  - Reset mid-operation abandons the in-flight memory request and discards buffered lines.
- Storage: NUM_ENTRIES circular FIFO of {line_addr, data}; head = oldest, tail = next free.
- c_is_ready = (state==IDLE) && (count<NUM_ENTRIES). Combinational.
- Accept: c_is_input_valid && c_is_ready. c_mem_read and c_mem_write are never both 1; if they are, the request is ignored.
- Write accept:
  - Line address matches a valid entry → that entry's data is overwritten (coalesce); count unchanged.
  - Otherwise the line is pushed at tail; tail wraps modulo NUM_ENTRIES; count+1.
  - No response pulse is generated.
- Read accept, buffer hit (address matches a valid entry):
  - Next cycle: c_dout = entry data, c_is_output_valid = 1 for one cycle.
  - No memory access; the entry stays buffered.
  - State stays IDLE.
- Read accept, buffer miss: latch address; go to RD_ISSUE.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, WR_WAIT.
  - IDLE: an accepted request has priority. Otherwise, if count>0 && m_mem_ready → WR_ISSUE.
  - RD_ISSUE: wait for m_mem_ready. In that cycle drive m_is_input_valid=1, m_mem_read=1, m_addr=latched → RD_WAIT.
  - RD_WAIT: on m_is_output_valid, register m_dout into c_dout; pulse c_is_output_valid the next cycle → IDLE.
  - WR_ISSUE: one cycle with m_is_input_valid=1, m_mem_write=1, m_addr/m_din = head entry → WR_WAIT.
  - WR_WAIT: the memory drops m_mem_ready the cycle after accepting. The first cycle with m_mem_ready=1 completes the write: head invalidated, head+1 (wraps), count-1 → IDLE.
- Memory-side outputs are registered and are 0 in every cycle not listed above.
- Read data returned from memory is never combined with buffer contents. This is correct because buffer-hit reads never reach memory.
- A drain issues only from IDLE with no request accepted in the same cycle. Upstream reads therefore bypass pending drains.
- Full (count==NUM_ENTRIES): c_is_ready=0 until a drain completes. Coalescing into a full buffer is not supported.
- Empty (count==0): no drain is issued; m_* outputs stay 0.
- Latencies:
  - Buffer-hit read: 1 cycle.
  - Miss read: memory latency + 2.
  - Drain occupancy: issue cycle + memory write latency.

Test Plan:
- Reset, then write line 0x100 data A → count=1. Memory idle → WR_ISSUE with m_addr=0x100, m_din=A, m_mem_write=1. After m_mem_ready returns → count=0, c_is_ready=1.
- Write 0x100=A, then write 0x100=B while memory held not-ready → count stays 1. Drain sends B only.
- Hold m_mem_ready=0; write 0x100, then 0x200 → count=2, c_is_ready=0. A write to 0x300 is not accepted. Release ready → 0x100 drains first, then 0x200; c_is_ready=1 after the first completes.
- Buffer holds 0x200=C; read 0x200 → c_is_output_valid pulses 1 cycle later with c_dout=C; m_is_input_valid stays 0.
- Buffer holds 0x200; read 0x400 in the same cycle a drain could start → the read issues first (m_mem_read=1, m_addr=0x400). Memory returns D → c_dout=D pulse. The drain of 0x200 follows.
- Reset asserted in WR_WAIT with count=2 → next cycle state=IDLE, count=0, all m_* outputs 0, c_is_ready=1.

Source files
------------

// File: rtl/writeback_buffer_if.sv
// ============================================================================
// Module   : writeback_buffer_if
// Brief    : Cache-side and memory-side signals of the line write-back buffer.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface writeback_buffer_if #(
  parameter int LINE_BITS = 128
);
  logic                 c_is_input_valid;
  logic [31:0]          c_addr;
  logic                 c_mem_read;
  logic                 c_mem_write;
  logic [LINE_BITS-1:0] c_din;
  logic                 c_is_ready;
  logic                 c_is_output_valid;
  logic [LINE_BITS-1:0] c_dout;

  logic                 m_is_input_valid;
  logic [31:0]          m_addr;
  logic                 m_mem_read;
  logic                 m_mem_write;
  logic [LINE_BITS-1:0] m_din;
  logic                 m_is_output_valid;
  logic [LINE_BITS-1:0] m_dout;
  logic                 m_mem_ready;

  // The buffer itself: receives cache requests, issues memory requests.
  modport slave (
    input  c_is_input_valid, c_addr, c_mem_read, c_mem_write, c_din,
    output c_is_ready, c_is_output_valid, c_dout,
    output m_is_input_valid, m_addr, m_mem_read, m_mem_write, m_din,
    input  m_is_output_valid, m_dout, m_mem_ready
  );

  // The surrounding cache and memory.
  modport master (
    output c_is_input_valid, c_addr, c_mem_read, c_mem_write, c_din,
    input  c_is_ready, c_is_output_valid, c_dout,
    input  m_is_input_valid, m_addr, m_mem_read, m_mem_write, m_din,
    output m_is_output_valid, m_dout, m_mem_ready
  );
endinterface

`default_nettype wire

// File: rtl/writeback_buffer.sv
// ============================================================================
// Module   : writeback_buffer
// Brief    : Line write-back buffer with coalescing, read forwarding and
//            oldest-first draining to memory when idle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module writeback_buffer #(
  parameter int LINE_SIZE   = 16,
  parameter int NUM_ENTRIES = 2,
  parameter int LINE_BITS   = LINE_SIZE * 8,
  parameter int OFS_BITS    = $clog2(LINE_SIZE / 4)
) (
  input  logic              clk,
  input  logic              reset,
  writeback_buffer_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] c_OFS_MASK = (32'd1 << OFS_BITS) - 32'd1;

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_RD_ISSUE = 3'd1;
  localparam logic [2:0] c_RD_WAIT  = 3'd2;
  localparam logic [2:0] c_WR_ISSUE = 3'd3;
  localparam logic [2:0] c_WR_WAIT  = 3'd4;

  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_count;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [NUM_ENTRIES-1:0] r_vld;
  logic [31:0]          r_addr [NUM_ENTRIES];
  logic [LINE_BITS-1:0] r_data [NUM_ENTRIES];
  logic [31:0]          r_rd_addr;

  logic                 r_c_valid;
  logic [LINE_BITS-1:0] r_c_dout;
  logic                 r_m_valid;
  logic [31:0]          r_m_addr;
  logic                 r_m_rd;
  logic                 r_m_wr;
  logic [LINE_BITS-1:0] r_m_din;

  logic [31:0]          w_line_addr;
  logic                 w_ready;
  logic                 w_accept;
  logic                 w_hit;
  logic [PTR_W-1:0]     w_hit_idx;

  assign w_line_addr = bus.c_addr & ~c_OFS_MASK;
  assign w_ready     = (r_state == c_IDLE) && (r_count < CNT_W'(NUM_ENTRIES));
  // A request with both read and write set is dropped and does not block a drain.
  assign w_accept    = bus.c_is_input_valid && w_ready && (bus.c_mem_read != bus.c_mem_write);

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (r_vld[i] && (r_addr[i] == w_line_addr)) begin
        w_hit     = 1'b1;
        w_hit_idx = PTR_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_count   <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_vld     <= '0;
      r_rd_addr <= '0;
      r_c_valid <= 1'b0;
      r_c_dout  <= '0;
      r_m_valid <= 1'b0;
      r_m_addr  <= '0;
      r_m_rd    <= 1'b0;
      r_m_wr    <= 1'b0;
      r_m_din   <= '0;
    end else begin
      r_c_valid <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_addr  <= '0;
      r_m_rd    <= 1'b0;
      r_m_wr    <= 1'b0;
      r_m_din   <= '0;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            if (bus.c_mem_write) begin
              if (w_hit) begin
                r_data[w_hit_idx] <= bus.c_din;
              end else begin
                r_addr[r_tail] <= w_line_addr;
                r_data[r_tail] <= bus.c_din;
                r_vld[r_tail]  <= 1'b1;
                r_tail         <= r_tail + PTR_W'(1);
                r_count        <= r_count + CNT_W'(1);
              end
            end else if (w_hit) begin
              r_c_dout  <= r_data[w_hit_idx];
              r_c_valid <= 1'b1;
            end else begin
              r_rd_addr <= w_line_addr;
              r_state   <= c_RD_ISSUE;
            end
          end else if ((r_count != '0) && bus.m_mem_ready) begin
            r_m_valid <= 1'b1;
            r_m_wr    <= 1'b1;
            r_m_addr  <= r_addr[r_head];
            r_m_din   <= r_data[r_head];
            r_state   <= c_WR_ISSUE;
          end
        end
        c_RD_ISSUE: begin
          if (bus.m_mem_ready) begin
            r_m_valid <= 1'b1;
            r_m_rd    <= 1'b1;
            r_m_addr  <= r_rd_addr;
            r_state   <= c_RD_WAIT;
          end
        end
        c_RD_WAIT: begin
          if (bus.m_is_output_valid) begin
            r_c_dout  <= bus.m_dout;
            r_c_valid <= 1'b1;
            r_state   <= c_IDLE;
          end
        end
        c_WR_ISSUE: r_state <= c_WR_WAIT;
        c_WR_WAIT: begin
          // Memory holds ready low while the write is in progress.
          if (bus.m_mem_ready) begin
            r_vld[r_head] <= 1'b0;
            r_head        <= r_head + PTR_W'(1);
            r_count       <= r_count - CNT_W'(1);
            r_state       <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign bus.c_is_ready        = w_ready;
  assign bus.c_is_output_valid = r_c_valid;
  assign bus.c_dout            = r_c_dout;
  assign bus.m_is_input_valid  = r_m_valid;
  assign bus.m_addr            = r_m_addr;
  assign bus.m_mem_read        = r_m_rd;
  assign bus.m_mem_write       = r_m_wr;
  assign bus.m_din             = r_m_din;

endmodule

`default_nettype wire
